// File: rtl/trap_causes_pkg.sv
// -----------------------------------------------------------------------------
// trap_causes: shared definitions for the machine-mode trap sequencer.
//   - exceptions : synchronous exception codes (mcause[3:0], is_int = 0)
//   - interrupts : machine interrupt codes (mcause[3:0], is_int = 1)
//   - CSR_*      : CSR addresses owned by trap_ctrl
//   - trap_state_t : sequencer FSM state encoding
// -----------------------------------------------------------------------------
package trap_causes;

   typedef enum logic [3:0] {
      EXC_INSN_MISALIGN  = 4'd0,
      EXC_INSN_FAULT     = 4'd1,
      EXC_ILLEGAL_INSN   = 4'd2,
      EXC_BREAKPOINT     = 4'd3,
      EXC_LOAD_MISALIGN  = 4'd4,
      EXC_LOAD_FAULT     = 4'd5,
      EXC_STORE_MISALIGN = 4'd6,
      EXC_STORE_FAULT    = 4'd7,
      EXC_ECALL_M        = 4'd11
   } exceptions;

   typedef enum logic [3:0] {
      IRQ_MSI = 4'd3,
      IRQ_MTI = 4'd7,
      IRQ_MEI = 4'd11
   } interrupts;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   // Only the three machine interrupt enables are implemented in mie.
   localparam logic [11:0] MIE_WMASK   = 12'h888;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } trap_state_t;

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// -----------------------------------------------------------------------------
// irq_prio: combinational eligible-interrupt priority encoder.
//   en        in  global enable (mstatus.MIE && pipeline interruptible)
//   mie       in  12-bit interrupt-enable CSR
//   irq_msip/irq_mtip/irq_meip  in  level-sensitive interrupt lines
//   irq_valid out an eligible interrupt exists
//   irq_code  out its cause code (MEI > MSI > MTI)
// -----------------------------------------------------------------------------
module irq_prio
   import trap_causes::*;
(
   input  logic        en,
   input  logic [11:0] mie,
   input  logic        irq_msip,
   input  logic        irq_mtip,
   input  logic        irq_meip,
   output logic        irq_valid,
   output logic [3:0]  irq_code
);

   // Fixed-priority selection among enabled, pending lines.
   always_comb begin
      irq_valid = 1'b0;
      irq_code  = 4'd0;
      if (en && mie[11] && irq_meip) begin
         irq_valid = 1'b1;
         irq_code  = IRQ_MEI;
      end else if (en && mie[3] && irq_msip) begin
         irq_valid = 1'b1;
         irq_code  = IRQ_MSI;
      end else if (en && mie[7] && irq_mtip) begin
         irq_valid = 1'b1;
         irq_code  = IRQ_MTI;
      end else begin
         irq_valid = 1'b0;
         irq_code  = 4'd0;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl: machine-mode trap sequencer.
// Arbitrates exception > interrupt > mret > CSR write while IDLE, updates the
// trap CSRs on the accepting edge and then holds one redirect request until
// fetch accepts it (busy stalls exec meanwhile).
// Ports:
//   clk, rst (async, active-high)
//   exc_valid/exc_cause/exc_pc/exc_tval  synchronous exception from exec
//   mret_valid                           mret retiring
//   int_ok/int_pc                        interruptible boundary + resume PC
//   irq_msip/irq_mtip/irq_meip           interrupt lines
//   mtvec                                trap vector CSR value
//   csr_we/csr_addr/csr_wdata            CSR write port
//   redirect_valid/ready/target          redirect handshake to fetch
//   busy                                 event in flight
//   mstatus_mie/mepc/mcause/mtval/mie    CSR read values
// Configuration: TRAP_VECTORED_EN enables vectored interrupt targets when
// mtvec[0] is set; undefined, every trap goes to the mtvec base.
// -----------------------------------------------------------------------------
`ifndef ALEN
`define ALEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module trap_ctrl
   import trap_causes::*;
#(
   parameter int ALEN = `ALEN,
   parameter int XLEN = `XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exc_valid,
   input  logic [3:0]      exc_cause,
   input  logic [ALEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            mret_valid,
   input  logic            int_ok,
   input  logic [ALEN-1:0] int_pc,
   input  logic            irq_msip,
   input  logic            irq_mtip,
   input  logic            irq_meip,
   input  logic [XLEN-1:0] mtvec,
   input  logic            csr_we,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic            redirect_valid,
   input  logic            redirect_ready,
   output logic [ALEN-1:0] redirect_target,
   output logic            busy,
   output logic            mstatus_mie,
   output logic [ALEN-1:0] mepc,
   output logic [XLEN-1:0] mcause,
   output logic [XLEN-1:0] mtval,
   output logic [11:0]     mie
);

   trap_state_t     state_q, state_d;
   logic            mie_q, mie_d;          // mstatus.MIE
   logic            mpie_q, mpie_d;        // mstatus.MPIE
   logic [11:0]     mie_en_q, mie_en_d;    // mie CSR
   logic [ALEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mtval_q, mtval_d;
   logic [ALEN-1:0] target_q, target_d;

   logic            irq_valid_s;
   logic [3:0]      irq_code_s;
   logic            unused_mtvec_s;

   // mtvec mode bits only matter for the vectored build.
   assign unused_mtvec_s = ^mtvec[1:0];

   irq_prio u_irq_prio (
      .en        (mie_q && int_ok),
      .mie       (mie_en_q),
      .irq_msip  (irq_msip),
      .irq_mtip  (irq_mtip),
      .irq_meip  (irq_meip),
      .irq_valid (irq_valid_s),
      .irq_code  (irq_code_s)
   );

   function automatic logic [ALEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                   input logic            is_int,
                                                   input logic [3:0]      code);
      logic [XLEN-1:0] base;
      base = {tvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
      if (is_int && tvec[0]) begin
         base = base + XLEN'({code, 2'b00});
      end else begin
         base = base;
      end
`else
      base = base + XLEN'({is_int & 1'b0, code & 4'd0});
`endif
      return ALEN'(base);
   endfunction

   // Next-state and CSR update logic; CSRs change only on the accepting edge.
   always_comb begin
      state_d  = state_q;
      mie_d    = mie_q;
      mpie_d   = mpie_q;
      mie_en_d = mie_en_q;
      mepc_d   = mepc_q;
      mcause_d = mcause_q;
      mtval_d  = mtval_q;
      target_d = target_q;
      case (state_q)
         IDLE: begin
            if (exc_valid) begin
               mepc_d   = {exc_pc[ALEN-1:1], 1'b0};
               mcause_d = {{(XLEN-4){1'b0}}, exc_cause};
               mtval_d  = exc_tval;
               mpie_d   = mie_q;
               mie_d    = 1'b0;
               target_d = trap_target(mtvec, 1'b0, exc_cause);
               state_d  = REDIRECT;
            end else if (irq_valid_s) begin
               mepc_d   = {int_pc[ALEN-1:1], 1'b0};
               mcause_d = {1'b1, {(XLEN-5){1'b0}}, irq_code_s};
               mtval_d  = {XLEN{1'b0}};
               mpie_d   = mie_q;
               mie_d    = 1'b0;
               target_d = trap_target(mtvec, 1'b1, irq_code_s);
               state_d  = REDIRECT;
            end else if (mret_valid) begin
               mie_d    = mpie_q;
               mpie_d   = 1'b1;
               target_d = mepc_q;
               state_d  = REDIRECT;
            end else if (csr_we) begin
               case (csr_addr)
                  CSR_MSTATUS: begin
                     mie_d  = csr_wdata[3];
                     mpie_d = csr_wdata[7];
                  end
                  CSR_MIE:    mie_en_d = csr_wdata[11:0] & MIE_WMASK;
                  CSR_MEPC:   mepc_d   = {csr_wdata[ALEN-1:1], 1'b0};
                  CSR_MCAUSE: mcause_d = csr_wdata;
                  CSR_MTVAL:  mtval_d  = csr_wdata;
                  default:    mie_en_d = mie_en_q;
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         REDIRECT: begin
            if (redirect_ready) begin
               state_d = IDLE;
            end else begin
               state_d = REDIRECT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and CSR registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         mie_en_q <= 12'd0;
         mepc_q   <= {ALEN{1'b0}};
         mcause_q <= {XLEN{1'b0}};
         mtval_q  <= {XLEN{1'b0}};
         target_q <= {ALEN{1'b0}};
      end else begin
         state_q  <= state_d;
         mie_q    <= mie_d;
         mpie_q   <= mpie_d;
         mie_en_q <= mie_en_d;
         mepc_q   <= mepc_d;
         mcause_q <= mcause_d;
         mtval_q  <= mtval_d;
         target_q <= target_d;
      end
   end

   assign busy            = (state_q == REDIRECT);
   assign redirect_valid  = (state_q == REDIRECT);
   assign redirect_target = target_q;
   assign mstatus_mie     = mie_q;
   assign mepc            = mepc_q;
   assign mcause          = mcause_q;
   assign mtval           = mtval_q;
   assign mie             = mie_en_q;

endmodule
